// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request front end for a 1-cycle-latency
// single-port SRAM. Turns accepted requests into single-cycle SRAM strobes
// and parks read data in a small credit-managed response FIFO, so that
// downstream backpressure can never drop a read result.
//
// Optional build macro: SRAM_REQ_CTRL_WACK_EN
//   defined   -> writes consume a credit and return an acknowledge response
//                (o_rsp_wr = 1, o_rsp_rdata = 0), ordered with read responses.
//   undefined -> writes return nothing, are never throttled, o_rsp_wr = 0.
module sram_req_ctrl #(
   parameter int ADDR_W    = 10,
   parameter int DATA_W    = 64,
   parameter int RSP_DEPTH = 2    // power of two, >= 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   // request stream
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_wr,
   input  logic [ADDR_W-1:0] i_req_addr,
   input  logic [DATA_W-1:0] i_req_wdata,
   input  logic [DATA_W-1:0] i_req_mask,
   // response stream
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_rdata,
   output logic              o_rsp_wr,
   // SRAM macro pins
   output logic              o_sram_cen,
   output logic              o_sram_wen,
   output logic [DATA_W-1:0] o_sram_bit_mask,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic [DATA_W-1:0] o_sram_wdata,
   input  logic [DATA_W-1:0] i_sram_rdata
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic              fire;
   logic              pop;
   logic              push;
   logic              full;
   logic              credit_ok;
   logic [CNT_W:0]    free;        // one bit wider than count: holds DEPTH + pop

   logic              rd_pend;     // a response-producing access was issued last cycle
   logic              pend_wr;     // that access was a write

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] push_data;
   logic [DATA_W-1:0] data_mem [RSP_DEPTH];
`ifdef SRAM_REQ_CTRL_WACK_EN
   logic              wr_mem   [RSP_DEPTH];
`endif

   // Credit accounting and request acceptance.
   // NOTE: every signal driven here gets a default at the top of the block;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      pop       = 1'b0;
      free      = '0;
      credit_ok = 1'b0;
      o_req_ready = 1'b0;

      pop  = o_rsp_valid & i_rsp_ready;
      // A slot freed by this cycle's pop can be re-promised at once, which is
      // what lets a full FIFO accept a new read in the same cycle it drains.
      free = (CNT_W+1)'(RSP_DEPTH) + (CNT_W+1)'(pop)
           - (CNT_W+1)'(count)     - (CNT_W+1)'(rd_pend);
      credit_ok = (free != '0);

      if (!i_rst) begin
`ifdef SRAM_REQ_CTRL_WACK_EN
         o_req_ready = credit_ok;
`else
         // Writes produce no response, so they never need a credit.
         o_req_ready = i_req_wr | credit_ok;
`endif
      end
   end

   // SRAM pin drive: strobes only on an accepted request, all pins quiet in reset.
   always_comb begin
      fire            = i_req_valid & o_req_ready;
      o_sram_cen      = fire;
      o_sram_wen      = fire & i_req_wr;
      o_sram_bit_mask = fire ? i_req_mask : '0;
      o_sram_addr     = i_rst ? '0 : i_req_addr;
      o_sram_wdata    = i_rst ? '0 : i_req_wdata;
   end

   // Track the access whose result lands on the SRAM read port next cycle.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_pend <= 1'b0;
         pend_wr <= 1'b0;
      end else begin
`ifdef SRAM_REQ_CTRL_WACK_EN
         rd_pend <= fire;
`else
         rd_pend <= fire & ~i_req_wr;
`endif
         pend_wr <= fire & i_req_wr;
      end
   end

   // Push side: capture SRAM read data (or a zero write-ack) one cycle after issue.
   always_comb begin
      push      = rd_pend;
      push_data = pend_wr ? '0 : i_sram_rdata;
      full      = (count == CNT_W'(RSP_DEPTH));
   end

   // FIFO pointers and occupancy; pointers wrap naturally on a power-of-two depth.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage.
   // NOTE: only entry 0 is reset; it is the head after reset, so this alone
   // keeps o_rsp_rdata/o_rsp_wr at 0, while the other entries stay plain
   // storage that is always written before it is read.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         data_mem[0] <= '0;
      end else if (push) begin
         data_mem[wr_ptr] <= push_data;
      end
   end

`ifdef SRAM_REQ_CTRL_WACK_EN
   // Response tag storage: marks write acknowledges.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_mem[0] <= 1'b0;
      end else if (push) begin
         wr_mem[wr_ptr] <= pend_wr;
      end
   end
`endif

   // Response outputs come straight from the head entry; no path from i_rsp_ready.
   always_comb begin
      o_rsp_valid = (count != '0);
      o_rsp_rdata = data_mem[rd_ptr];
`ifdef SRAM_REQ_CTRL_WACK_EN
      o_rsp_wr    = wr_mem[rd_ptr];
`else
      o_rsp_wr    = 1'b0;
`endif
   end

   // Credit accounting guarantees a slot for every pending push.
   a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
                                    !(push && full && !pop));

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: scoreboard bench for sram_req_ctrl. A behavioural SRAM
// answers the DUT pins; a separate reference memory, updated from accepted
// requests, predicts each response and queues it. A monitor pops and compares
// whenever a response is handed over. Honours SRAM_REQ_CTRL_WACK_EN.
module tb_sram_req_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;

   logic              i_clk;
   logic              i_rst;
   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_wr;
   logic [ADDR_W-1:0] i_req_addr;
   logic [DATA_W-1:0] i_req_wdata;
   logic [DATA_W-1:0] i_req_mask;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DATA_W-1:0] o_rsp_rdata;
   logic              o_rsp_wr;
   logic              o_sram_cen;
   logic              o_sram_wen;
   logic [DATA_W-1:0] o_sram_bit_mask;
   logic [ADDR_W-1:0] o_sram_addr;
   logic [DATA_W-1:0] o_sram_wdata;
   logic [DATA_W-1:0] i_sram_rdata;

   sram_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSP_DEPTH(2)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_req_valid     (i_req_valid),
      .o_req_ready     (o_req_ready),
      .i_req_wr        (i_req_wr),
      .i_req_addr      (i_req_addr),
      .i_req_wdata     (i_req_wdata),
      .i_req_mask      (i_req_mask),
      .o_rsp_valid     (o_rsp_valid),
      .i_rsp_ready     (i_rsp_ready),
      .o_rsp_rdata     (o_rsp_rdata),
      .o_rsp_wr        (o_rsp_wr),
      .o_sram_cen      (o_sram_cen),
      .o_sram_wen      (o_sram_wen),
      .o_sram_bit_mask (o_sram_bit_mask),
      .o_sram_addr     (o_sram_addr),
      .o_sram_wdata    (o_sram_wdata),
      .i_sram_rdata    (i_sram_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int cyc;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Behavioural SRAM: masked write, one-cycle read latency, noise otherwise.
   logic [DATA_W-1:0] sram_mem [1024];
   always @(posedge i_clk) begin
      if (o_sram_cen && o_sram_wen)
         sram_mem[o_sram_addr] <= (sram_mem[o_sram_addr] & ~o_sram_bit_mask)
                                | (o_sram_wdata & o_sram_bit_mask);
      if (o_sram_cen && !o_sram_wen)
         i_sram_rdata <= sram_mem[o_sram_addr];
      else
         i_sram_rdata <= {$urandom, $urandom};
   end

   // Reference model and scoreboard.
   typedef struct {
      logic              wr;
      logic [DATA_W-1:0] data;
      int                issue;
   } exp_t;

   logic [DATA_W-1:0] ref_mem [1024];
   exp_t              sb [$];
   int                checks;
   int                errors;
   bit                strict_lat;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One request cycle: drive at negedge, decide acceptance just before posedge.
   task automatic drive(input bit v, input bit wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m,
                        input bit rr, output bit fired);
      @(negedge i_clk);
      i_req_valid = v;
      i_req_wr    = wr;
      i_req_addr  = a;
      i_req_wdata = d;
      i_req_mask  = m;
      i_rsp_ready = rr;
      #4;
      fired = i_req_valid && o_req_ready;
      if (fired) begin
         if (wr) begin
            ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
`ifdef SRAM_REQ_CTRL_WACK_EN
            sb.push_back('{wr: 1'b1, data: '0, issue: cyc});
`endif
         end else begin
            sb.push_back('{wr: 1'b0, data: ref_mem[a], issue: cyc});
         end
      end
   endtask

   task automatic idle(input int n, input bit rr);
      bit f;
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, '0, rr, f);
   endtask

   task automatic set_rst(input bit r);
      @(negedge i_clk);
      i_rst       = r;
      i_req_valid = 1'b0;
      i_req_wr    = 1'b0;
      i_rsp_ready = 1'b0;
      #4;
   endtask

   // Monitor: compare every handed-over response against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge i_clk);
         #4;
         if (!i_rst && o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: actual rdata=%0h wr=%0b required=no response (cycle %0d)",
                        o_rsp_rdata, o_rsp_wr, cyc);
            end else begin
               e = sb.pop_front();
               check("rsp_rdata", o_rsp_rdata, e.data);
               check("rsp_wr", {63'd0, o_rsp_wr}, {63'd0, e.wr});
               if (strict_lat) check("rsp_latency", 64'(cyc - e.issue), 64'd2);
            end
         end
      end
   end

   initial begin
      bit                fired;
      int                n;
      bit                wr;
      logic [DATA_W-1:0] all1;

      all1        = '1;
      i_rst       = 1'b1;
      i_req_valid = 1'b0;
      i_req_wr    = 1'b0;
      i_req_addr  = '0;
      i_req_wdata = '0;
      i_req_mask  = '0;
      i_rsp_ready = 1'b0;
      strict_lat  = 1'b1;

      // Reset: a live-looking request must leave every pin quiet.
      drive(1'b1, 1'b1, 10'h3FF, all1, all1, 1'b1, fired);
      check("rst_req_ready",  {63'd0, o_req_ready}, 64'd0);
      check("rst_sram_cen",   {63'd0, o_sram_cen},  64'd0);
      check("rst_sram_wen",   {63'd0, o_sram_wen},  64'd0);
      check("rst_sram_mask",  o_sram_bit_mask,      64'd0);
      check("rst_sram_addr",  {54'd0, o_sram_addr}, 64'd0);
      check("rst_sram_wdata", o_sram_wdata,         64'd0);
      check("rst_rsp_valid",  {63'd0, o_rsp_valid}, 64'd0);
      check("rst_rsp_rdata",  o_rsp_rdata,          64'd0);
      check("rst_rsp_wr",     {63'd0, o_rsp_wr},    64'd0);
      set_rst(1'b0);

      // Full-mask write then read-back of 0x005.
      drive(1'b1, 1'b1, 10'h005, 64'hDEAD_BEEF_0123_4567, all1, 1'b1, fired);
      check("t1_wr_fire", {63'd0, fired}, 64'd1);
      drive(1'b1, 1'b0, 10'h005, '0, '0, 1'b1, fired);
      check("t1_rd_fire", {63'd0, fired}, 64'd1);
      idle(3, 1'b1);

      // Half mask: ones written over zero at 0x3FF.
      drive(1'b1, 1'b1, 10'h3FF, '0, all1, 1'b1, fired);
      drive(1'b1, 1'b1, 10'h3FF, all1, 64'h0000_0000_FFFF_FFFF, 1'b1, fired);
      drive(1'b1, 1'b0, 10'h3FF, '0, '0, 1'b1, fired);
      check("t2_rd_fire", {63'd0, fired}, 64'd1);
      idle(3, 1'b1);

      // Prefill 0..15, then 16 back-to-back reads with no stall.
      for (int i = 0; i < 16; i++)
         drive(1'b1, 1'b1, 10'(i), {$urandom, $urandom}, all1, 1'b1, fired);
      idle(3, 1'b1);
      n = 0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b0, 10'(i), '0, '0, 1'b1, fired);
         n += int'(fired);
      end
      check("t3_reads_accepted", 64'(n), 64'd16);
      idle(3, 1'b1);

      // Backpressure: only two reads fit; refill happens on the first pop.
      strict_lat = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 10'(i), '0, '0, 1'b0, fired);
         n += int'(fired);
      end
      check("t4_bp_accepted", 64'(n), 64'd2);
      drive(1'b1, 1'b0, 10'h007, '0, '0, 1'b1, fired);
      check("t4_refill_fire", {63'd0, fired}, 64'd1);
      check("t4_refill_pop",  {63'd0, o_rsp_valid}, 64'd1);
      idle(4, 1'b1);

      // Reset with one response queued and one read in flight.
      drive(1'b1, 1'b0, 10'h001, '0, '0, 1'b0, fired);
      drive(1'b1, 1'b0, 10'h002, '0, '0, 1'b0, fired);
      set_rst(1'b1);
      sb.delete();
      set_rst(1'b0);
      check("t5_rsp_valid_after_rst", {63'd0, o_rsp_valid}, 64'd0);
      check("t5_req_ready_after_rst", {63'd0, o_req_ready}, 64'd1);
      idle(5, 1'b1);

`ifdef SRAM_REQ_CTRL_WACK_EN
      // Write acknowledge ordered ahead of the following read.
      strict_lat = 1'b1;
      drive(1'b1, 1'b1, 10'h009, {$urandom, $urandom}, all1, 1'b1, fired);
      check("t6_wack_wr_fire", {63'd0, fired}, 64'd1);
      drive(1'b1, 1'b0, 10'h009, '0, '0, 1'b1, fired);
      check("t6_wack_rd_fire", {63'd0, fired}, 64'd1);
      idle(3, 1'b1);
      strict_lat = 1'b0;
`else
      // FIFO full: writes still pass, reads are held off.
      drive(1'b1, 1'b0, 10'h003, '0, '0, 1'b0, fired);
      drive(1'b1, 1'b0, 10'h004, '0, '0, 1'b0, fired);
      drive(1'b1, 1'b1, 10'h00A, {$urandom, $urandom}, all1, 1'b0, fired);
      check("t6_wr_when_full", {63'd0, fired}, 64'd1);
      drive(1'b1, 1'b0, 10'h00A, '0, '0, 1'b0, fired);
      check("t6_rd_blocked_full", {63'd0, fired}, 64'd0);
      idle(4, 1'b1);
`endif

      // Random traffic with random backpressure over 16 hot addresses.
      for (int i = 0; i < 400; i++) begin
         wr = ($urandom_range(0, 2) == 0);
         drive($urandom_range(0, 3) != 0, wr, 10'($urandom_range(0, 15)),
               {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 3) != 0, fired);
      end

      // Bounded drain.
      for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1, 1'b1);
      check("drain_empty", 64'(sb.size()), 64'd0);
      idle(2, 1'b1);
      check("end_rsp_valid", {63'd0, o_rsp_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_req_ctrl.md
# sram_req_ctrl

Request/response front end for the 1024x64 single-port SRAM macro used by local_mem and in_out_mem. Converts a valid/ready request stream (read or masked write) into single-cycle SRAM enable/write strobes. Captures the one-cycle-latency read data into a response FIFO so that downstream backpressure never loses data. Sits directly upstream of the SRAM wrapper and drives its enable, write, mask, address and write-data pins.

## Interface
Parameters:
- ADDR_W, 10, SRAM word address width
- DATA_W, 64, data and bit-mask width
- RSP_DEPTH, 2, response FIFO entries; power of two, ≥2

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_req_valid  in  1  request valid
- o_req_ready  out  1  request accepted when valid&ready (fire)
- i_req_wr  in  1  1 = write, 0 = read
- i_req_addr  in  ADDR_W  word address
- i_req_wdata  in  DATA_W  write data
- i_req_mask  in  DATA_W  per-bit write enable, 1 = write bit
- o_rsp_valid  out  1  response valid
- i_rsp_ready  in  1  response consumed when valid&ready
- o_rsp_rdata  out  DATA_W  read data
- o_rsp_wr  out  1  response belongs to a write (always 0 unless WACK enabled)
- o_sram_cen  out  1  SRAM enable, active-high
- o_sram_wen  out  1  SRAM write enable, active-high
- o_sram_bit_mask  out  DATA_W  SRAM write mask
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_wdata  out  DATA_W  SRAM write data
- i_sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read enable

## Operation
- o_sram_cen = fire; o_sram_wen = fire & i_req_wr; o_sram_addr/wdata/bit_mask pass i_req_* through combinationally. When fire=0, the wen and bit_mask outputs are forced to 0.
- rd_pend: 1-bit register, set on a read fire (or on any fire when WACK is enabled), cleared otherwise. The tag register pend_wr records i_req_wr.
- In the cycle with rd_pend=1: push {pend_wr, pend_wr ? 0 : i_sram_rdata} into the FIFO.
- Credit: free = RSP_DEPTH − count − rd_pend + (o_rsp_valid & i_rsp_ready).
- o_req_ready = !i_rst & (free > 0). Writes without WACK ignore credit (o_req_ready = !i_rst whenever i_req_wr=1).
- FIFO: wr_ptr, rd_ptr of log2(RSP_DEPTH) bits, wrapping naturally; count of log2(RSP_DEPTH)+1 bits. Simultaneous push and pop leave count unchanged. Push into a full FIFO cannot occur by construction; flag it as an assertion.
- o_rsp_valid = count≠0; o_rsp_rdata and o_rsp_wr come from the head entry.
- Reset: count, pointers, rd_pend and pend_wr go to 0. o_rsp_valid=0, o_rsp_rdata=0 and o_rsp_wr=0 (head storage is cleared at entry 0). All o_sram_* = 0 and o_req_ready=0 while i_rst=1.
- Reset mid-operation: in-flight reads and queued responses are dropped. The SRAM contents are not touched.
- Requests are never reordered; responses return in issue order.

## Timing
- Read fire in cycle T; SRAM samples at the end of T; i_sram_rdata is valid in T+1 and pushed at the end of T+1. o_rsp_valid is first high in T+2. Read latency = 2 cycles.
- Write takes effect at the end of the fire cycle. A read of the same address fired in T+1 returns the new data.
- Sustained throughput is 1 read/cycle when i_rsp_ready is held high and RSP_DEPTH ≥ 2.
- No combinational path from i_rsp_ready to o_rsp_valid. o_req_ready depends combinationally on i_rsp_ready (through the free term) and on i_req_wr.

## Configuration
- SRAM_REQ_CTRL_WACK_EN: when defined, writes consume credit and produce a response with o_rsp_wr=1 and o_rsp_rdata=0, in order with reads.
- When undefined, writes produce no response and are never throttled. o_rsp_wr is tied to 0.

## Test plan
- Write addr 0x005, data 0xDEAD_BEEF_0123_4567, mask all-1; then read 0x005 -> o_rsp_rdata=0xDEAD_BEEF_0123_4567, with o_rsp_valid 2 cycles after the read fire.
- Mask 0x0000_0000_FFFF_FFFF, write data all-1 over 0 at 0x3FF -> read returns 0x0000_0000_FFFF_FFFF.
- 16 back-to-back reads of addr 0..15, i_rsp_ready=1 -> 16 responses on consecutive cycles starting at cycle 2, in order, o_req_ready never low.
- i_rsp_ready=0 with continuous read valid -> exactly 2 accepted, then o_req_ready=0. Raising i_rsp_ready drains both, and the next read is accepted in the same cycle as the first pop.
- Assert i_rst for 1 cycle while 1 read is in flight and 1 response is queued -> o_rsp_valid=0 next cycle, no stale response appears, and o_req_ready=1 after reset.
- With WACK: write then read -> response 1 has o_rsp_wr=1 and rdata=0; response 2 has o_rsp_wr=0. Without WACK: a write with the FIFO full is still accepted.
